// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, access-op encoding, mstatus bit positions
// and the read-modify-write helpers used by csr_unit.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS       = 12'h300;
   localparam logic [11:0] CSR_MIE           = 12'h304;
   localparam logic [11:0] CSR_MTVEC         = 12'h305;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MEPC          = 12'h341;
   localparam logic [11:0] CSR_MCAUSE        = 12'h342;
   localparam logic [11:0] CSR_MIP           = 12'h344;
   localparam logic [11:0] CSR_DPC           = 12'h7B1;
   localparam logic [11:0] CSR_DSCRATCH0     = 12'h7B2;
   localparam logic [11:0] CSR_DSCRATCH1     = 12'h7B3;
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_INSTRET       = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
   localparam logic [11:0] CSR_MHARTID       = 12'hF14;

   typedef enum logic [1:0] {
      OP_RD = 2'b00,
      OP_RW = 2'b01,
      OP_RS = 2'b10,
      OP_RC = 2'b11
   } csr_op_e;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;
   localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;

   // RS/RC with a zero operand behave as pure reads, matching csrrs/csrrc with rs1=x0.
   function automatic logic csr_is_write(input logic [1:0] op, input logic [31:0] wdata);
      return (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && (wdata != 32'h0));
   endfunction

   function automatic logic [31:0] csr_apply(input logic [1:0] op, input logic [31:0] old,
                                             input logic [31:0] wdata);
      logic [31:0] res;
      case (op)
         OP_RW:   res = wdata;
         OP_RS:   res = old | wdata;
         OP_RC:   res = old & ~wdata;
         default: res = old;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running CNT_W-bit counter with inhibit and independent 32-bit half loads;
// a half load takes precedence over (and suppresses) that cycle's increment.
module csr_counter #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inhibit,
   input  logic             inc,
   input  logic             load_lo,
   input  logic             load_hi,
   input  logic [31:0]      wdata,
   output logic [CNT_W-1:0] value
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (load_lo) begin
         value[31:0] <= wdata;
      end else if (load_hi) begin
         value[CNT_W-1:32] <= wdata[CNT_W-33:0];
      end else if (inc && !inhibit) begin
         value <= value + ONE;
      end
   end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap/mret sequencing and cycle/instret counters.
// Define CSR_DEBUG_EN to add the dpc/dscratch0/dscratch1 debug registers.
module csr_unit
   import csr_pkg::*;
#(
   parameter logic [31:0] HART_ID   = 32'd0,
   parameter logic [31:0] MTVEC_RST = 32'h0,
   parameter int          CNT_W     = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exu_req_i,
   input  logic [1:0]  exu_op_i,
   input  logic [11:0] exu_addr_i,
   input  logic [31:0] exu_wdata_i,
   output logic [31:0] exu_rdata_o,
   output logic        exu_illegal_o,
   input  logic        instret_i,
   input  logic        trap_i,
   input  logic [31:0] trap_cause_i,
   input  logic [31:0] trap_pc_i,
   input  logic        mret_i,
   input  logic        irq_sw_i,
   input  logic        irq_timer_i,
   input  logic        irq_ext_i,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o,
   output logic [31:0] mstatus_o,
   output logic [31:0] mie_o,
   output logic [31:0] mip_o,
   output logic [31:0] dpc_o,
   output logic        irq_pending_o
);

   logic [31:0] mtvec, mepc, mcause, mie, mstatus, mscratch, mcountinhibit, mip;
   logic [CNT_W-1:0] mcycle, minstret;
`ifdef CSR_DEBUG_EN
   logic [31:0] dpc, dscratch0, dscratch1;
`endif

   logic        hit;
   logic        wr_req;
   logic        wr_en;
   logic [31:0] rdata;
   logic [31:0] new_val;
   logic [31:0] mstatus_trap;
   logic [31:0] mstatus_mret;

   always_comb begin
      hit   = 1'b1;
      rdata = 32'h0;
      case (exu_addr_i)
         CSR_MSTATUS:              rdata = mstatus;
         CSR_MIE:                  rdata = mie;
         CSR_MTVEC:                rdata = mtvec;
         CSR_MCOUNTINHIBIT:        rdata = mcountinhibit;
         CSR_MSCRATCH:             rdata = mscratch;
         CSR_MEPC:                 rdata = mepc;
         CSR_MCAUSE:               rdata = mcause;
         CSR_MIP:                  rdata = mip;
         CSR_MHARTID:              rdata = HART_ID;
         CSR_MCYCLE, CSR_CYCLE:     rdata = mcycle[31:0];
         CSR_MCYCLEH, CSR_CYCLEH:   rdata = 32'(mcycle[CNT_W-1:32]);
         CSR_MINSTRET, CSR_INSTRET: rdata = minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: rdata = 32'(minstret[CNT_W-1:32]);
`ifdef CSR_DEBUG_EN
         CSR_DPC:                  rdata = dpc;
         CSR_DSCRATCH0:            rdata = dscratch0;
         CSR_DSCRATCH1:            rdata = dscratch1;
`endif
         default:                  hit = 1'b0;
      endcase
   end

   // Address space 0xCxx/0xFxx is read-only; writing it is an illegal access.
   assign wr_req        = csr_is_write(exu_op_i, exu_wdata_i);
   assign exu_illegal_o = exu_req_i && (!hit || (wr_req && (exu_addr_i[11:10] == 2'b11)));
   assign wr_en         = exu_req_i && wr_req && !exu_illegal_o;
   assign new_val       = csr_apply(exu_op_i, rdata, exu_wdata_i);
   assign exu_rdata_o   = rdata;

   always_comb begin
      mstatus_trap = mstatus;
      mstatus_trap[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
      mstatus_trap[MSTATUS_MIE]  = 1'b0;
      mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      mstatus_mret = mstatus;
      mstatus_mret[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
      mstatus_mret[MSTATUS_MPIE] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtvec         <= MTVEC_RST;
         mepc          <= 32'h0;
         mcause        <= 32'h0;
         mie           <= 32'h0;
         mstatus       <= 32'h0;
         mscratch      <= 32'h0;
         mcountinhibit <= 32'h0;
         mip           <= 32'h0;
      end else begin
         mip <= {20'h0, irq_ext_i, 3'b000, irq_timer_i, 3'b000, irq_sw_i, 3'b000};
         if (wr_en && (exu_addr_i == CSR_MTVEC))         mtvec         <= new_val;
         if (wr_en && (exu_addr_i == CSR_MIE))           mie           <= new_val;
         if (wr_en && (exu_addr_i == CSR_MSCRATCH))      mscratch      <= new_val;
         if (wr_en && (exu_addr_i == CSR_MCOUNTINHIBIT)) mcountinhibit <= new_val;
         // Trap beats mret beats the EXU for the registers they touch.
         if (trap_i) begin
            mepc    <= trap_pc_i;
            mcause  <= trap_cause_i;
            mstatus <= mstatus_trap;
         end else begin
            if (wr_en && (exu_addr_i == CSR_MEPC))   mepc   <= new_val;
            if (wr_en && (exu_addr_i == CSR_MCAUSE)) mcause <= new_val;
            if (mret_i)
               mstatus <= mstatus_mret;
            else if (wr_en && (exu_addr_i == CSR_MSTATUS))
               mstatus <= new_val & MSTATUS_MASK;
         end
      end
   end

`ifdef CSR_DEBUG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         dpc       <= 32'h0;
         dscratch0 <= 32'h0;
         dscratch1 <= 32'h0;
      end else begin
         if (wr_en && (exu_addr_i == CSR_DPC))       dpc       <= new_val;
         if (wr_en && (exu_addr_i == CSR_DSCRATCH0)) dscratch0 <= new_val;
         if (wr_en && (exu_addr_i == CSR_DSCRATCH1)) dscratch1 <= new_val;
      end
   end
   assign dpc_o = dpc;
`else
   assign dpc_o = 32'h0;
`endif

   csr_counter #(.CNT_W(CNT_W)) u_mcycle (
      .clk     (clk),
      .rst     (rst),
      .inhibit (mcountinhibit[0]),
      .inc     (1'b1),
      .load_lo (wr_en && (exu_addr_i == CSR_MCYCLE)),
      .load_hi (wr_en && (exu_addr_i == CSR_MCYCLEH)),
      .wdata   (new_val),
      .value   (mcycle)
   );

   csr_counter #(.CNT_W(CNT_W)) u_minstret (
      .clk     (clk),
      .rst     (rst),
      .inhibit (mcountinhibit[2]),
      .inc     (instret_i),
      .load_lo (wr_en && (exu_addr_i == CSR_MINSTRET)),
      .load_hi (wr_en && (exu_addr_i == CSR_MINSTRETH)),
      .wdata   (new_val),
      .value   (minstret)
   );

   assign mtvec_o       = mtvec;
   assign mepc_o        = mepc;
   assign mstatus_o     = mstatus;
   assign mie_o         = mie;
   assign mip_o         = mip;
   assign irq_pending_o = mstatus[MSTATUS_MIE] && |(mie & mip);

endmodule
